dequantize_nf4_unpack_lut: RTL



---
 rtl/dequantize_nf4_unpack_lut.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dequantize_nf4_unpack_lut.sv
`default_nettype none
// ============================================================================
// Module      : dequantize_nf4_unpack_lut
// Description : Unpacks 32-bit words of eight NF4 codes, maps each code
//               through the fixed NF4 codebook to a signed Q2.6 byte and
//               streams (code value, block scale) pairs to the 8s x 8s
//               multiplier at one element per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dequantize_nf4_unpack_lut #(
    parameter int BLOCK_SIZE = 64,   // elements sharing one scale, multiple of 8
    parameter int WORD_W     = 32,   // packed word width (eight nibbles)
    parameter bit LOW_FIRST  = 1'b1  // 1: nibble [3:0] first, 0: nibble [31:28] first
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [WORD_W-1:0] packed_data,
    input  logic              packed_valid,
    output logic              packed_ready,
    input  logic [7:0]        scale_data,
    input  logic              scale_valid,
    output logic              scale_ready,
    output logic [7:0]        out_code,
    output logic [7:0]        out_scale,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(BLOCK_SIZE - 1);

    localparam logic [1:0] S_SCALE = 2'd0;
    localparam logic [1:0] S_WORD  = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;

    logic [1:0]        r_state;
    logic [WORD_W-1:0] r_word;
    logic [2:0]        r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [7:0]        r_scale;

    logic [7:0]        r_out_code;
    logic [7:0]        r_out_scale;
    logic              r_out_last;
    logic              r_out_valid;

    logic              w_adv;
    logic              w_cnt_last;
    logic              w_packed_ready;
    logic              w_scale_ready;
    logic              w_word_hs;
    logic              w_scale_hs;
    logic              w_load;
    logic [WORD_W-1:0] w_src_word;
    logic [2:0]        w_src_idx;
    logic [2:0]        w_sel;
    logic [3:0]        w_nibble;

    // NF4 codebook in signed Q2.6, fixed at design time
    function automatic logic [7:0] nf4_lut(input logic [3:0] code);
        logic [7:0] v;
        case (code)
            4'h0:    v = 8'hC0;  // -64
            4'h1:    v = 8'hD3;  // -45
            4'h2:    v = 8'hDE;  // -34
            4'h3:    v = 8'hE7;  // -25
            4'h4:    v = 8'hEE;  // -18
            4'h5:    v = 8'hF4;  // -12
            4'h6:    v = 8'hFA;  // -6
            4'h7:    v = 8'h00;  //  0
            4'h8:    v = 8'h05;  //  5
            4'h9:    v = 8'h0A;  // 10
            4'hA:    v = 8'h10;  // 16
            4'hB:    v = 8'h16;  // 22
            4'hC:    v = 8'h1C;  // 28
            4'hD:    v = 8'h24;  // 36
            4'hE:    v = 8'h2E;  // 46
            default: v = 8'h40;  // 64
        endcase
        return v;
    endfunction

    assign w_adv      = !r_out_valid || out_ready;
    assign w_cnt_last = (r_cnt == c_LAST_CNT);

    // Ready generation: depends only on state, counters and out_ready, and is
    // held low while reset is asserted so reset values read as zero.
    always_comb begin
        w_packed_ready = 1'b0;
        w_scale_ready  = 1'b0;
        if (!ap_rst) begin
            case (r_state)
                S_SCALE: w_scale_ready  = 1'b1;
                S_WORD:  w_packed_ready = 1'b1;
                S_EMIT:  w_packed_ready = (r_idx == 3'd7) && w_adv && !w_cnt_last;
                default: w_packed_ready = 1'b0;
            endcase
        end
    end

    assign w_word_hs  = packed_valid && w_packed_ready;
    assign w_scale_hs = scale_valid && w_scale_ready;

    // In S_WORD the first nibble is taken straight from the incoming word so
    // the first element appears one cycle after the word handshake.
    assign w_src_word = (r_state == S_WORD) ? packed_data : r_word;
    assign w_src_idx  = (r_state == S_WORD) ? 3'd0 : r_idx;
    assign w_sel      = LOW_FIRST ? w_src_idx : (3'd7 - w_src_idx);
    assign w_nibble   = w_src_word[{w_sel, 2'b00} +: 4];

    assign w_load = w_adv && ((r_state == S_EMIT) ||
                              ((r_state == S_WORD) && w_word_hs));

    // Output register: loads a new element on advance, otherwise drains to idle
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_out_code  <= 8'h00;
            r_out_scale <= 8'h00;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            if (w_load) begin
                r_out_code  <= nf4_lut(w_nibble);
                r_out_scale <= r_scale;
                r_out_last  <= w_cnt_last;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Sequencer: scale, then words of the block, then back to scale
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= S_SCALE;
            r_word  <= '0;
            r_idx   <= 3'd0;
            r_cnt   <= '0;
            r_scale <= 8'h00;
        end else begin
            case (r_state)
                S_SCALE: begin
                    if (w_scale_hs) begin
                        r_scale <= scale_data;
                        r_state <= S_WORD;
                    end
                end
                S_WORD: begin
                    if (w_word_hs) begin
                        r_word  <= packed_data;
                        r_state <= S_EMIT;
                        if (w_adv) begin
                            // nibble 0 already went to the output register
                            r_idx <= 3'd1;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end else begin
                            r_idx <= 3'd0;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_adv) begin
                        if (w_cnt_last) begin
                            r_cnt   <= '0;
                            r_idx   <= 3'd0;
                            r_state <= S_SCALE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            if (r_idx == 3'd7) begin
                                r_idx <= 3'd0;
                                if (w_word_hs) begin
                                    // back-to-back word, no bubble
                                    r_word <= packed_data;
                                end else begin
                                    r_state <= S_WORD;
                                end
                            end else begin
                                r_idx <= r_idx + 3'd1;
                            end
                        end
                    end
                end
                default: r_state <= S_SCALE;
            endcase
        end
    end

    assign packed_ready = w_packed_ready;
    assign scale_ready  = w_scale_ready;
    assign out_code     = r_out_code;
    assign out_scale    = r_out_scale;
    assign out_last     = r_out_last;
    assign out_valid    = r_out_valid;

endmodule
`default_nettype wire
